// File: rtl/d_latch_pkg.sv
// Shared definitions for the D-latch input path.
// Holds the debounce FSM state encoding, default parameter values and the
// glitch counter saturation limit.
package d_latch_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CHECK  = 2'd1,
      COMMIT = 2'd2
   } state_t;

   localparam int SYNC_STAGES_DEF   = 2;
   localparam int STABLE_CYCLES_DEF = 4;

   localparam logic [7:0] GLITCH_MAX = 8'd255;

endpackage

// File: rtl/d_debounce_strobe_if.sv
// Signal bundle between the debounce front end and whatever drives/consumes it.
//   din_raw, hold          : driven by master, sampled by slave
//   d, enable, busy,
//   glitch_cnt             : driven by slave, observed by master
interface d_debounce_strobe_if;

   logic       din_raw;
   logic       hold;
   logic       d;
   logic       enable;
   logic       busy;
   logic [7:0] glitch_cnt;

   modport master (
      output din_raw,
      output hold,
      input  d,
      input  enable,
      input  busy,
      input  glitch_cnt
   );

   modport slave (
      input  din_raw,
      input  hold,
      output d,
      output enable,
      output busy,
      output glitch_cnt
   );

endinterface

// File: rtl/d_debounce_strobe_sync_chain.sv
// N-flop synchroniser for an asynchronous single-bit input.
//   clk   : sampling clock
//   rst_n : asynchronous active-low reset, clears every stage to 0
//   din   : asynchronous input
//   dout  : synchronised output (last stage)
module sync_chain #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout
);

   logic [STAGES-1:0] q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else begin
         q <= {q[STAGES-2:0], din};
      end
   end

   assign dout = q[STAGES-1];

endmodule

// File: rtl/d_debounce_strobe.sv
// Debounce front end for the D-latch stage. Synchronises din_raw, requires a
// changed value to persist for STABLE_CYCLES synchronised cycles, then updates
// d and pulses enable for one cycle. Rejected transitions bump a saturating
// glitch counter.
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : slave side of d_debounce_strobe_if
//            (din_raw, hold in; d, enable, busy, glitch_cnt out)
//
// state  | meaning
// IDLE   | d matches sync_q, or hold is blocking qualification
// CHECK  | candidate differs from d, counting stable cycles in cnt
// COMMIT | d just updated and enable high; always back to IDLE next edge
module d_debounce_strobe
   import d_latch_pkg::*;
#(
   parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
   parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
   parameter int CNT_W         = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   d_debounce_strobe_if.slave   bus
);

   localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(STABLE_CYCLES);

   logic             sync_q;
   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             d_q;
   logic             en_q;
   logic             busy_q;
   logic [7:0]       glitch_q;

   sync_chain #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (bus.din_raw),
      .dout  (sync_q)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         d_q      <= 1'b0;
         en_q     <= 1'b0;
         busy_q   <= 1'b0;
         glitch_q <= 8'd0;
      end else begin
         en_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (!bus.hold && (sync_q != d_q)) begin
                  state  <= CHECK;
                  cnt    <= CNT_W'(1);
                  busy_q <= 1'b1;
               end
            end
            CHECK: begin
               if (bus.hold) begin
                  state  <= IDLE;
                  cnt    <= '0;
                  busy_q <= 1'b0;
               end else if (sync_q == d_q) begin
                  // candidate bounced back before qualifying
                  state  <= IDLE;
                  cnt    <= '0;
                  busy_q <= 1'b0;
                  if (glitch_q != GLITCH_MAX) begin
                     glitch_q <= glitch_q + 8'd1;
                  end
               end else if (cnt == STABLE_CNT) begin
                  state <= COMMIT;
                  cnt   <= '0;
                  d_q   <= sync_q;
                  en_q  <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            COMMIT: begin
               // hold deliberately ignored so an accepted value always lands
               state  <= IDLE;
               busy_q <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               cnt    <= '0;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.d          = d_q;
   assign bus.enable     = en_q;
   assign bus.busy       = busy_q;
   assign bus.glitch_cnt = glitch_q;

endmodule

// File: tb/tb_d_debounce_strobe.sv
// Directed bench for d_debounce_strobe with default parameters
// (SYNC_STAGES=2, STABLE_CYCLES=4). Inputs change 1 ns after a rising edge,
// outputs are sampled 1 ns after the following rising edge.
module tb_d_debounce_strobe;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   d_debounce_strobe_if bus_if ();

   d_debounce_strobe dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   typedef struct {
      logic       din;
      logic       hold;
      logic       exp_d;
      logic       exp_en;
      logic       exp_busy;
      logic [7:0] exp_glitch;
   } vec_t;

   vec_t tbl[$];

   int checks = 0;
   int errors = 0;

   function automatic vec_t mk(input logic din, input logic hold, input logic ed,
                               input logic een, input logic eb, input logic [7:0] eg);
      vec_t v;
      v.din = din; v.hold = hold; v.exp_d = ed; v.exp_en = een;
      v.exp_busy = eb; v.exp_glitch = eg;
      return v;
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick(input logic din, input logic hold);
      bus_if.din_raw = din;
      bus_if.hold    = hold;
      @(posedge clk);
      #1;
   endtask

   task automatic step(input logic din, input logic hold, input logic ed, input logic een,
                       input logic eb, input logic [7:0] eg, input string tag);
      tick(din, hold);
      chk({tag, ".d"},      {7'd0, bus_if.d},      {7'd0, ed});
      chk({tag, ".enable"}, {7'd0, bus_if.enable}, {7'd0, een});
      chk({tag, ".busy"},   {7'd0, bus_if.busy},   {7'd0, eb});
      chk({tag, ".glitch"}, bus_if.glitch_cnt,     eg);
   endtask

   initial begin
      logic en_seen;

      // clean rise: strobe on edge 7 (2 sync + 4 stable + 1)
      for (int k = 1; k <= 10; k++)
         tbl.push_back(mk(1'b1, 1'b0, k >= 7, k == 7, (k >= 3 && k <= 7), 8'd0));
      // clean fall, same timing
      for (int k = 1; k <= 10; k++)
         tbl.push_back(mk(1'b0, 1'b0, k < 7, k == 7, (k >= 3 && k <= 7), 8'd0));
      // back-to-back: synchronised fall lands during COMMIT, second strobe 6 edges later
      for (int k = 1; k <= 15; k++)
         tbl.push_back(mk(k <= 5, 1'b0, (k >= 7 && k <= 12), (k == 7 || k == 13),
                          ((k >= 3 && k <= 7) || (k >= 9 && k <= 13)), 8'd0));

      rst_n          = 1'b0;
      bus_if.din_raw = 1'b0;
      bus_if.hold    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst.d",      {7'd0, bus_if.d},      8'd0);
      chk("rst.enable", {7'd0, bus_if.enable}, 8'd0);
      chk("rst.busy",   {7'd0, bus_if.busy},   8'd0);
      chk("rst.glitch", bus_if.glitch_cnt,     8'd0);
      rst_n = 1'b1;

      for (int k = 0; k < 20; k++)
         step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, $sformatf("quiet%0d", k));

      foreach (tbl[i])
         step(tbl[i].din, tbl[i].hold, tbl[i].exp_d, tbl[i].exp_en,
              tbl[i].exp_busy, tbl[i].exp_glitch, $sformatf("tbl%0d", i));

      // single 3-cycle glitch: rejected on edge 6
      for (int k = 1; k <= 10; k++)
         step(k <= 3, 1'b0, 1'b0, 1'b0, (k >= 3 && k <= 5), (k >= 6) ? 8'd1 : 8'd0,
              $sformatf("glitch%0d", k));

      // hold abort on second CHECK cycle, restart after hold drops (edge 9 -> strobe edge 13)
      for (int k = 1; k <= 16; k++)
         step(1'b1, (k >= 5 && k <= 8), k >= 13, k == 13,
              ((k >= 3 && k <= 4) || (k >= 9 && k <= 13)), 8'd1, $sformatf("hold%0d", k));

      repeat (10) tick(1'b0, 1'b0);
      chk("fall_after_hold.d", {7'd0, bus_if.d}, 8'd0);

      // saturation: 299 more glitches on top of the one already counted
      en_seen = 1'b0;
      for (int p = 1; p <= 299; p++) begin
         for (int k = 1; k <= 8; k++) begin
            tick(k <= 3, 1'b0);
            en_seen = en_seen | bus_if.enable;
         end
         if (p == 253) chk("glitch_254", bus_if.glitch_cnt, 8'd254);
         if (p == 254) chk("glitch_255", bus_if.glitch_cnt, 8'd255);
      end
      chk("glitch_sat",       bus_if.glitch_cnt,      8'd255);
      chk("glitch_no_strobe", {7'd0, en_seen},        8'd0);
      chk("glitch_d",         {7'd0, bus_if.d},       8'd0);

      // async reset while falling candidate has cnt=2
      repeat (10) tick(1'b1, 1'b0);
      chk("pre_rst.d", {7'd0, bus_if.d}, 8'd1);
      repeat (4) tick(1'b0, 1'b0);
      chk("pre_rst.busy", {7'd0, bus_if.busy}, 8'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst.d",      {7'd0, bus_if.d},      8'd0);
      chk("async_rst.enable", {7'd0, bus_if.enable}, 8'd0);
      chk("async_rst.busy",   {7'd0, bus_if.busy},   8'd0);
      chk("async_rst.glitch", bus_if.glitch_cnt,     8'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int k = 0; k < 8; k++)
         step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, $sformatf("post_rst%0d", k));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
